// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake bundle between the datapath control (master)
// and the ALU operation sequencer (slave).
interface alu_op_sequencer_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic [2:0]       req_op;
   logic [TAG_W-1:0] req_tag;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_zero;
   logic             rsp_illegal;

   modport master (
      output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_tag, rsp_zero, rsp_illegal
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_tag, rsp_zero, rsp_illegal
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Drives a combinational ALU for SETTLE cycles per accepted request, samples
// its Result and hands back a tagged response; one operation in flight.
module alu_op_sequencer #(
   parameter int WIDTH  = 32,
   parameter int SETTLE = 1,
   parameter int TAG_W  = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   alu_op_sequencer_if.slave bus,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   output logic [2:0]        alu_op,
   input  logic [WIDTH-1:0]  alu_result,
   output logic              busy,
   output logic [CNT_W-1:0]  ops_done,
   output logic [CNT_W-1:0]  ops_illegal
);

   if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("alu_op_sequencer: SETTLE=%0d is outside 1..15", SETTLE);
   end

   localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state_q;
   logic [3:0]       settleCnt_q;
   logic             reqReady_q;
   logic             rspValid_q;
   logic [WIDTH-1:0] rspResult_q;
   logic [TAG_W-1:0] rspTag_q;
   logic             rspZero_q;
   logic             rspIllegal_q;
   logic [WIDTH-1:0] aluA_q;
   logic [WIDTH-1:0] aluB_q;
   logic [2:0]       aluOp_q;
   logic             busy_q;
   logic [CNT_W-1:0] opsDone_q;
   logic [CNT_W-1:0] opsIllegal_q;

   logic             reqIllegal;
   logic [CNT_W-1:0] opsDone_d;
   logic [CNT_W-1:0] opsIllegal_d;

   // 011, 100 and 101 are the unassigned ALUOp encodings.
   assign reqIllegal = (bus.req_op == 3'b011) || (bus.req_op == 3'b100) ||
                       (bus.req_op == 3'b101);

   assign opsDone_d    = (&opsDone_q)    ? opsDone_q    : opsDone_q    + CNT_W'(1);
   assign opsIllegal_d = (&opsIllegal_q) ? opsIllegal_q : opsIllegal_q + CNT_W'(1);

   // The ALU drive registers double as the operand capture; illegal ops leave them alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         settleCnt_q  <= '0;
         reqReady_q   <= 1'b1;
         rspValid_q   <= 1'b0;
         rspResult_q  <= '0;
         rspTag_q     <= '0;
         rspZero_q    <= 1'b0;
         rspIllegal_q <= 1'b0;
         aluA_q       <= '0;
         aluB_q       <= '0;
         aluOp_q      <= '0;
         busy_q       <= 1'b0;
         opsDone_q    <= '0;
         opsIllegal_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  rspTag_q   <= bus.req_tag;
                  reqReady_q <= 1'b0;
                  busy_q     <= 1'b1;
                  if (reqIllegal) begin
                     state_q      <= HOLD;
                     rspResult_q  <= '0;
                     rspZero_q    <= 1'b1;
                     rspIllegal_q <= 1'b1;
                     rspValid_q   <= 1'b1;
                  end else begin
                     state_q      <= DRIVE;
                     settleCnt_q  <= SETTLE_CNT;
                     rspIllegal_q <= 1'b0;
                     aluA_q       <= bus.req_a;
                     aluB_q       <= bus.req_b;
                     aluOp_q      <= bus.req_op;
                  end
               end
            end
            DRIVE: begin
               settleCnt_q <= settleCnt_q - 4'd1;
               if (settleCnt_q == 4'd1) begin
                  rspResult_q <= alu_result;
                  rspZero_q   <= (alu_result == '0);
                  rspValid_q  <= 1'b1;
                  state_q     <= HOLD;
               end
            end
            HOLD: begin
               if (bus.rsp_ready) begin
                  state_q    <= IDLE;
                  rspValid_q <= 1'b0;
                  reqReady_q <= 1'b1;
                  busy_q     <= 1'b0;
                  opsDone_q  <= opsDone_d;
                  if (rspIllegal_q) begin
                     opsIllegal_q <= opsIllegal_d;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Structural invariants: no overlap between accept and response, busy tracks the FSM.
   assert property (@(posedge clk) !(reqReady_q && rspValid_q));
   assert property (@(posedge clk) busy_q == (state_q != IDLE));

   assign bus.req_ready   = reqReady_q;
   assign bus.rsp_valid   = rspValid_q;
   assign bus.rsp_result  = rspResult_q;
   assign bus.rsp_tag     = rspTag_q;
   assign bus.rsp_zero    = rspZero_q;
   assign bus.rsp_illegal = rspIllegal_q;
   assign alu_a           = aluA_q;
   assign alu_b           = aluB_q;
   assign alu_op          = aluOp_q;
   assign busy            = busy_q;
   assign ops_done        = opsDone_q;
   assign ops_illegal     = opsIllegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: table of directed ALU requests on a SETTLE=1
// instance, plus hand sequences for backpressure and mid-operation reset (SETTLE=3).
`timescale 1ns/1ps
module tb_alu_op_sequencer;
   localparam int WIDTH = 32;
   localparam int TAG_W = 4;
   localparam int CNT_W = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic rst3;

   alu_op_sequencer_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();
   alu_op_sequencer_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus3 ();

   logic [WIDTH-1:0] aluA, aluB, aluResult;
   logic [WIDTH-1:0] aluA3, aluB3, aluResult3;
   logic [2:0]       aluOp, aluOp3;
   logic             busy, busy3;
   logic [CNT_W-1:0] opsDone, opsIllegal, opsDone3, opsIllegal3;

   alu_op_sequencer #(.WIDTH(WIDTH), .SETTLE(1), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .alu_a(aluA), .alu_b(aluB), .alu_op(aluOp), .alu_result(aluResult),
      .busy(busy), .ops_done(opsDone), .ops_illegal(opsIllegal)
   );

   alu_op_sequencer #(.WIDTH(WIDTH), .SETTLE(3), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut3 (
      .clk(clk), .rst(rst3), .bus(bus3),
      .alu_a(aluA3), .alu_b(aluB3), .alu_op(aluOp3), .alu_result(aluResult3),
      .busy(busy3), .ops_done(opsDone3), .ops_illegal(opsIllegal3)
   );

   // Behavioural stand-in for the combinational ALU the sequencer drives.
   function automatic logic [WIDTH-1:0] aluModel(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [2:0] op);
      case (op)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a + b;
         3'b110:  return a - b;
         3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return '0;
      endcase
   endfunction

   assign aluResult  = aluModel(aluA, aluB, aluOp);
   assign aluResult3 = aluModel(aluA3, aluB3, aluOp3);

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [2:0]       op;
      logic [TAG_W-1:0] tag;
      logic [WIDTH-1:0] expResult;
      logic             expZero;
      logic             expIllegal;
   } vec_t;

   vec_t vecs[12];

   int checks = 0;
   int failures = 0;
   int expDone = 0;
   int expIll = 0;
   logic [2:0]       lastOp = 3'b000;
   logic [WIDTH-1:0] lastA  = '0;

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                              input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      int lat;
      @(negedge clk);
      checkOutput($sformatf("v%0d req_ready idle", idx), 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_a     = v.a;
      bus.req_b     = v.b;
      bus.req_op    = v.op;
      bus.req_tag   = v.tag;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_a     = 32'hDEADBEEF;
      bus.req_op    = 3'b001;
      lat = 1;
      while (!bus.rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checkOutput($sformatf("v%0d latency", idx), 32'(lat), v.expIllegal ? 32'd1 : 32'd2);
      checkOutput($sformatf("v%0d rsp_result", idx), bus.rsp_result, v.expResult);
      checkOutput($sformatf("v%0d rsp_tag", idx), 32'(bus.rsp_tag), 32'(v.tag));
      checkOutput($sformatf("v%0d rsp_zero", idx), 32'(bus.rsp_zero), 32'(v.expZero));
      checkOutput($sformatf("v%0d rsp_illegal", idx), 32'(bus.rsp_illegal), 32'(v.expIllegal));
      checkOutput($sformatf("v%0d req_ready hold", idx), 32'(bus.req_ready), 32'd0);
      if (!v.expIllegal) begin
         lastOp = v.op;
         lastA  = v.a;
      end
      checkOutput($sformatf("v%0d alu_op", idx), 32'(aluOp), 32'(lastOp));
      checkOutput($sformatf("v%0d alu_a", idx), aluA, lastA);
      expDone++;
      if (v.expIllegal) expIll++;
      @(negedge clk);
      checkOutput($sformatf("v%0d rsp_valid drop", idx), 32'(bus.rsp_valid), 32'd0);
      checkOutput($sformatf("v%0d ops_done", idx), 32'(opsDone), 32'(expDone));
      checkOutput($sformatf("v%0d ops_illegal", idx), 32'(opsIllegal), 32'(expIll));
   endtask

   task automatic runOp3(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] op, input logic [TAG_W-1:0] tag,
                         input logic [WIDTH-1:0] expRes, input string name);
      int lat;
      @(negedge clk);
      bus3.req_valid = 1'b1;
      bus3.req_a     = a;
      bus3.req_b     = b;
      bus3.req_op    = op;
      bus3.req_tag   = tag;
      bus3.rsp_ready = 1'b1;
      @(negedge clk);
      bus3.req_valid = 1'b0;
      lat = 1;
      while (!bus3.rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checkOutput({name, " latency"}, 32'(lat), 32'd4);
      checkOutput({name, " rsp_result"}, bus3.rsp_result, expRes);
      checkOutput({name, " rsp_tag"}, 32'(bus3.rsp_tag), 32'(tag));
      @(negedge clk);
      checkOutput({name, " ops_done"}, 32'(opsDone3), 32'd1);
   endtask

   initial begin
      int lat;
      vecs[0]  = '{32'd1,         32'd2,         3'b010, 4'd3,  32'd3,         1'b0, 1'b0};
      vecs[1]  = '{32'd3,         32'd4,         3'b110, 4'd5,  32'hFFFFFFFF,  1'b0, 1'b0};
      vecs[2]  = '{32'd12,        32'd10,        3'b000, 4'd1,  32'd8,         1'b0, 1'b0};
      vecs[3]  = '{32'd12,        32'd10,        3'b001, 4'd2,  32'd14,        1'b0, 1'b0};
      vecs[4]  = '{32'hFFFFFFFB,  32'd5,         3'b111, 4'd4,  32'd1,         1'b0, 1'b0};
      vecs[5]  = '{32'd10,        32'hFFFFFFFE,  3'b111, 4'd6,  32'd0,         1'b1, 1'b0};
      vecs[6]  = '{32'd7,         32'd9,         3'b011, 4'd7,  32'd0,         1'b1, 1'b1};
      vecs[7]  = '{32'h7FFFFFFF,  32'd1,         3'b010, 4'd8,  32'h80000000,  1'b0, 1'b0};
      vecs[8]  = '{32'd5,         32'd5,         3'b110, 4'd9,  32'd0,         1'b1, 1'b0};
      vecs[9]  = '{32'd1,         32'd1,         3'b100, 4'd10, 32'd0,         1'b1, 1'b1};
      vecs[10] = '{32'd1,         32'd1,         3'b101, 4'd11, 32'd0,         1'b1, 1'b1};
      vecs[11] = '{32'hF0F0F0F0,  32'h0FF00FF0,  3'b000, 4'd12, 32'h00F000F0,  1'b0, 1'b0};

      rst  = 1'b1;
      rst3 = 1'b1;
      bus.req_valid  = 1'b0; bus.req_a  = '0; bus.req_b  = '0; bus.req_op  = '0; bus.req_tag  = '0;
      bus.rsp_ready  = 1'b0;
      bus3.req_valid = 1'b0; bus3.req_a = '0; bus3.req_b = '0; bus3.req_op = '0; bus3.req_tag = '0;
      bus3.rsp_ready = 1'b0;
      repeat (2) @(negedge clk);

      checkOutput("reset req_ready", 32'(bus.req_ready), 32'd1);
      checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset ops_done", 32'(opsDone), 32'd0);
      checkOutput("reset alu_op", 32'(aluOp), 32'd0);
      checkOutput("reset rsp_result", bus.rsp_result, 32'd0);
      rst  = 1'b0;
      rst3 = 1'b0;

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i], i);
      end

      // Backpressure: response held for five cycles, stray request ignored.
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1; bus.req_a = 32'd7; bus.req_b = 32'd8; bus.req_op = 3'b010; bus.req_tag = 4'd13;
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("bp latency", 32'(lat), 32'd2);
      for (int c = 0; c < 5; c++) begin
         checkOutput($sformatf("bp c%0d rsp_valid", c), 32'(bus.rsp_valid), 32'd1);
         checkOutput($sformatf("bp c%0d rsp_result", c), bus.rsp_result, 32'd15);
         checkOutput($sformatf("bp c%0d rsp_tag", c), 32'(bus.rsp_tag), 32'd13);
         checkOutput($sformatf("bp c%0d req_ready", c), 32'(bus.req_ready), 32'd0);
         if (c == 2) begin
            bus.req_valid = 1'b1; bus.req_a = 32'd100; bus.req_op = 3'b001; bus.req_tag = 4'd14;
         end else begin
            bus.req_valid = 1'b0;
         end
         @(negedge clk);
      end
      checkOutput("bp ops_done held", 32'(opsDone), 32'(expDone));
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      expDone++;
      checkOutput("bp rsp_valid drop", 32'(bus.rsp_valid), 32'd0);
      checkOutput("bp ops_done", 32'(opsDone), 32'(expDone));
      @(negedge clk);
      checkOutput("bp no ghost busy", 32'(busy), 32'd0);
      checkOutput("bp no ghost rsp", 32'(bus.rsp_valid), 32'd0);
      checkOutput("bp alu_a kept", aluA, 32'd7);
      checkOutput("bp idle rsp_ready ignored", 32'(opsDone), 32'(expDone));

      // SETTLE=3: one clean op, then reset in DRIVE, then a fresh op.
      runOp3(32'd20, 32'd22, 3'b010, 4'd1, 32'd42, "s3 first");
      @(negedge clk);
      bus3.req_valid = 1'b1; bus3.req_a = 32'd5; bus3.req_b = 32'd6; bus3.req_op = 3'b010; bus3.req_tag = 4'd2;
      @(negedge clk);
      bus3.req_valid = 1'b0;
      checkOutput("s3 in drive busy", 32'(busy3), 32'd1);
      checkOutput("s3 in drive alu_a", aluA3, 32'd5);
      rst3 = 1'b1;
      @(negedge clk);
      checkOutput("s3 rst req_ready", 32'(bus3.req_ready), 32'd1);
      checkOutput("s3 rst rsp_valid", 32'(bus3.rsp_valid), 32'd0);
      checkOutput("s3 rst busy", 32'(busy3), 32'd0);
      checkOutput("s3 rst ops_done", 32'(opsDone3), 32'd0);
      checkOutput("s3 rst alu_a", aluA3, 32'd0);
      rst3 = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("s3 no late rsp", 32'(bus3.rsp_valid), 32'd0);
      runOp3(32'd100, 32'd1, 3'b110, 4'd3, 32'd99, "s3 after rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
